timed_bus_selector: RTL
=======================

// Module: timed_bus_selector
// PURPOSE
//   Parametrised successor to the 4:1 timed selector: N-channel, W-bit registered bus mux.
//   Loads only on programmable timing beats of the one-hot timing bus T.
//   Two modes: addressed (addr picks channel) and round-robin (fair scan of requesting channels).
//   Adds load-valid pulse, selected-channel report, hold/stall input and bad-address flag.
//   Sits between the register/ALU sources and the internal data bus of the model computer.
// PARAMETERS
//   W       8            data width per channel
//   N       4            channel count, 2..16
//   AW      $clog2(N)    select/address width (derived; do not override)
//   TW      8            width of timing bus T
//   T_MASK  8'b0001_0100 beats that load the output (default T[4] | T[2])
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   rst_n      in   1      synchronous reset, active low
//   T          in   TW     one-hot timing beats from the timing generator
//   mode       in   1      0 = addressed, 1 = round-robin
//   addr       in   AW     channel select in addressed mode
//   req        in   N      per-channel request, used in round-robin mode only
//   hold       in   1      stall; suppresses loading while high
//   D          in   N*W    flattened inputs; channel k = D[k*W +: W]
//   OUT        out  W      registered selected data
//   out_valid  out  1      one-cycle pulse: OUT loaded on this edge
//   out_sel    out  AW     channel index currently held in OUT
//   err        out  1      one-cycle pulse: addressed load with addr >= N
// BEHAVIOUR
//   Reset (rst_n == 0 at an edge)
//   - OUT = 0, out_valid = 0, out_sel = 0, err = 0, rr_ptr = N-1.
//   - Reset overrides every other input.
//   Load strobe
//   - strobe = |(T & T_MASK) & ~hold.
//   - Several masked beats high at once still give a single load.
//   - No strobe: OUT, out_sel and rr_ptr hold; out_valid = 0 and err = 0 next cycle.
//   Addressed mode (mode = 0), on strobe:
//   - addr < N: OUT <= D[addr], out_sel <= addr, out_valid <= 1.
//   - addr >= N (only possible when N is not a power of 2): OUT and out_sel hold,
//     out_valid <= 0, err <= 1.
//   - rr_ptr is not modified.
//   Round-robin mode (mode = 1), on strobe:
//   - Scan req from index rr_ptr+1 upward, wrapping mod N; rr_ptr itself is checked last.
//   - First set bit g wins: OUT <= D[g], out_sel <= g, rr_ptr <= g, out_valid <= 1.
//   - req == 0: OUT, out_sel and rr_ptr hold; out_valid <= 0; err stays 0.
//   - Single requester: wins on every strobe, including when it is rr_ptr itself.
//   Common rules
//   - Latency: D, addr, req and mode are sampled at the strobe edge; OUT is valid after that edge.
//   - mode may change on any cycle; it takes effect at the next strobe.
//   - Switching modes never resets rr_ptr.
//   - hold is level-sensitive; a strobe beat that occurs under hold is lost, not deferred.
//   - No combinational path from any input to any output.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles with T=8'h14 -> OUT=0, out_valid=0, out_sel=0, err=0 throughout.
//   2 Addressed, N=4: D2=8'hA5, addr=2, T=8'b0000_0100 -> next edge OUT=A5, out_sel=2, out_valid=1;
//     T=8'b0000_1000 -> OUT stays A5, out_valid=0.
//   3 Hold: addr=1, D1=8'h3C, T[4]=1, hold=1 -> OUT unchanged, out_valid=0;
//     next T[2] beat with hold=0 -> OUT=3C.
//   4 Round-robin, N=4: req=4'b1011 on consecutive strobes -> out_sel sequence 0,1,3,0,1;
//     then req=0 -> OUT holds, out_valid=0, rr_ptr unchanged.
//   5 Bad address, N=5 (AW=3): addr=6 on strobe -> err=1 for one cycle, OUT/out_sel hold;
//     then addr=4 -> OUT=D4, err=0.
//   6 Mid-operation reset: rst_n=0 coincident with a strobe while rr_ptr=2 -> reset values win;
//     first RR strobe after reset with req=4'b1111 -> out_sel=0.

Source files
------------

// File: rtl/timed_bus_selector.sv
// N-channel W-bit registered bus mux loading on masked timing beats; addressed or round-robin select.
// Latency: inputs sampled at the strobe edge, OUT/out_sel/out_valid/err valid after it; hold suppresses (drops) strobes.
module timed_bus_selector #(
    parameter int              W      = 8,
    parameter int              N      = 4,
    parameter int              AW     = $clog2(N),
    parameter int              TW     = 8,
    parameter logic [TW-1:0]   T_MASK = TW'(8'b0001_0100)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TW-1:0]     T,
    input  logic              mode,
    input  logic [AW-1:0]     addr,
    input  logic [N-1:0]      req,
    input  logic              hold,
    input  logic [N*W-1:0]    D,
    output logic [W-1:0]      OUT,
    output logic              out_valid,
    output logic [AW-1:0]     out_sel,
    output logic              err
);

    logic [W-1:0]  out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_sel_q, out_sel_d;
    logic          err_q, err_d;
    logic [AW-1:0] rr_ptr_q, rr_ptr_d;

    logic          strobe;
    logic          addr_ok;
    logic          rr_found;
    logic [AW-1:0] rr_grant;
    logic [AW-1:0] pick;
    logic [W-1:0]  pick_dat;

    assign strobe = (|(T & T_MASK)) & ~hold;

    // Scan starts just past the last winner so rr_ptr itself is considered last.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int i = 1; i <= N; i++) begin
            if (!rr_found && req[(int'(rr_ptr_q) + i) % N]) begin
                rr_found = 1'b1;
                rr_grant = AW'((int'(rr_ptr_q) + i) % N);
            end
        end
    end

    always_comb begin
        addr_ok  = int'(addr) < N;
        pick     = mode ? rr_grant : addr;
        pick_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (AW'(k) == pick) begin
                pick_dat = D[k*W +: W];
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        if (strobe) begin
            if (!mode) begin
                if (addr_ok) begin
                    out_d       = pick_dat;
                    out_sel_d   = pick;
                    out_valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (rr_found) begin
                out_d       = pick_dat;
                out_sel_d   = pick;
                rr_ptr_d    = pick;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            err_q       <= 1'b0;
            rr_ptr_q    <= AW'(N - 1);
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            err_q       <= err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign OUT       = out_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign err       = err_q;

endmodule
